hps_uio_responder: RTL and testbench

Core-side responder for the MiSTer-style HPS user-I/O bus that the 832 MCU drives as initiator through its register-mapped IO_UIO/IO_FPGA/IO_STROBE/IO_DOUT lines. It decodes UIO command transactions and latches the results into core-facing registers: buttons, two joysticks, a 32-bit status word and, optionally, a PS/2 key event. It also returns readback data and a wait flag on IO_DIN/IO_WAIT. It sits in the same clock domain as the MCU and is instantiated once per core.

---
 rtl/hps_uio_responder.sv | 210 +++++++++++++++++++++
 tb/tb_hps_uio_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_uio_responder.sv
// hps_uio_responder: HPS user-I/O command responder.
// Define HPS_UIO_PS2_EN to compile in the PS/2 key command (0x05).
module hps_uio_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IO_UIO,
  input  logic        IO_FPGA,
  input  logic        IO_STROBE,
  input  logic [15:0] IO_DOUT,
  output logic        IO_WAIT,
  output logic [15:0] IO_DIN,
  output logic [15:0] buttons,
  output logic [31:0] joystick_0,
  output logic [31:0] joystick_1,
  output logic [31:0] status,
  output logic        status_updated,
  output logic [10:0] ps2_key
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_e;

  state_e      state_q, state_d;
  logic        stb_q, det_q, take;
  logic [15:0] dat_q;
  logic [7:0]  cmd_q, cmd_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] stg_q, stg_d;
  logic [15:0] din_q, din_d;
  logic [15:0] btn_q, btn_d;
  logic [31:0] j0_q, j0_d;
  logic [31:0] j1_q, j1_d;
  logic [31:0] st_q, st_d;
  logic        upd_q, upd_d;
  logic        c_btn, c_j0, c_j1, c_st, c_rd;
`ifdef HPS_UIO_PS2_EN
  logic        c_ps2;
  logic [10:0] ps2_q, ps2_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
`endif

  assign c_btn = (cmd_q == 8'h01);
  assign c_j0  = (cmd_q == 8'h02);
  assign c_j1  = (cmd_q == 8'h03);
  assign c_st  = (cmd_q == 8'h1E);
  assign c_rd  = (cmd_q == 8'h29);
`ifdef HPS_UIO_PS2_EN
  assign c_ps2 = (cmd_q == 8'h05);
`endif

  // Strobe rising-edge detect, registered with its data word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_q <= 1'b0;
      det_q <= 1'b0;
      dat_q <= '0;
    end else begin
      stb_q <= IO_STROBE;
      det_q <= IO_STROBE & ~stb_q & IO_UIO & ~IO_FPGA;
      dat_q <= IO_DOUT;
    end
  end

  // A detected word is only acted on if the transaction is still open.
  assign take = det_q & IO_UIO & (state_q != S_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; a UIO drop always returns to idle.
  always_comb begin
    state_d = state_q;
    if (!IO_UIO) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_CMD;
        S_CMD:   state_d = take ? S_DATA : S_CMD;
        default: state_d = state_q;
      endcase
    end
  end

  // Command/data decode into next-state datapath values.
  always_comb begin
    cmd_d  = cmd_q;
    idx_d  = idx_q;
    stg_d  = stg_q;
    din_d  = din_q;
    btn_d  = btn_q;
    j0_d   = j0_q;
    j1_d   = j1_q;
    st_d   = st_q;
    upd_d  = 1'b0;
    wcnt_d = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
`ifdef HPS_UIO_PS2_EN
    ps2_d  = ps2_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
`endif
    if (take) wcnt_d = 4'(WAIT_CYCLES);
    if (!IO_UIO) begin
      cmd_d = '0;
      idx_d = '0;
      stg_d = '0;
      din_d = '0;
`ifdef HPS_UIO_PS2_EN
      ext_d = 1'b0;
      rel_d = 1'b0;
`endif
    end else if (take && state_q == S_CMD) begin
      cmd_d = dat_q[7:0];
      idx_d = '0;
      din_d = (dat_q[7:0] == 8'h29) ? st_q[15:0] : '0;
    end else if (take && state_q == S_DATA && idx_q != 4'hF) begin
      idx_d = idx_q + 4'd1;
      din_d = '0;
      unique case (1'b1)
        c_btn: if (idx_q == 4'd0) btn_d = dat_q;
        c_j0: begin
          if (idx_q == 4'd0) j0_d[15:0]  = dat_q;
          if (idx_q == 4'd1) j0_d[31:16] = dat_q;
        end
        c_j1: begin
          if (idx_q == 4'd0) j1_d[15:0]  = dat_q;
          if (idx_q == 4'd1) j1_d[31:16] = dat_q;
        end
        c_st: begin
          if (idx_q == 4'd0) stg_d = dat_q;
          if (idx_q == 4'd1) begin
            st_d  = {dat_q, stg_q};
            upd_d = 1'b1;
          end
        end
        c_rd: if (idx_q == 4'd0) din_d = st_q[31:16];
`ifdef HPS_UIO_PS2_EN
        c_ps2: begin
          if (dat_q[7:0] == 8'hE0) begin
            ext_d = 1'b1;
          end else if (dat_q[7:0] == 8'hF0) begin
            rel_d = 1'b1;
          end else begin
            ps2_d = {~ps2_q[10], ~rel_q, ext_q, dat_q[7:0]};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q  <= '0;
      idx_q  <= '0;
      wcnt_q <= '0;
      stg_q  <= '0;
      din_q  <= '0;
      btn_q  <= '0;
      j0_q   <= '0;
      j1_q   <= '0;
      st_q   <= '0;
      upd_q  <= 1'b0;
`ifdef HPS_UIO_PS2_EN
      ps2_q  <= '0;
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
`endif
    end else begin
      cmd_q  <= cmd_d;
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
      stg_q  <= stg_d;
      din_q  <= din_d;
      btn_q  <= btn_d;
      j0_q   <= j0_d;
      j1_q   <= j1_d;
      st_q   <= st_d;
      upd_q  <= upd_d;
`ifdef HPS_UIO_PS2_EN
      ps2_q  <= ps2_d;
      ext_q  <= ext_d;
      rel_q  <= rel_d;
`endif
    end
  end

  assign IO_WAIT        = (wcnt_q != 4'd0);
  assign IO_DIN         = din_q;
  assign buttons        = btn_q;
  assign joystick_0     = j0_q;
  assign joystick_1     = j1_q;
  assign status         = st_q;
  assign status_updated = upd_q;
`ifdef HPS_UIO_PS2_EN
  assign ps2_key        = ps2_q;
`else
  assign ps2_key        = '0;
`endif

endmodule

// File: tb/tb_hps_uio_responder.sv
// tb_hps_uio_responder: directed checks of the UIO responder.
// Drives on negedge, samples on negedge.
module tb_hps_uio_responder;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IO_UIO, IO_FPGA, IO_STROBE;
  logic [15:0] IO_DOUT;
  logic        IO_WAIT;
  logic [15:0] IO_DIN;
  logic [15:0] buttons;
  logic [31:0] joystick_0, joystick_1, status;
  logic        status_updated;
  logic [10:0] ps2_key;

  int errs = 0;
  int checks = 0;
  int upd_cnt = 0;
  int wait_hi = 0;
  int w0;

  hps_uio_responder #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset_n(reset_n),
    .IO_UIO(IO_UIO), .IO_FPGA(IO_FPGA),
    .IO_STROBE(IO_STROBE), .IO_DOUT(IO_DOUT),
    .IO_WAIT(IO_WAIT), .IO_DIN(IO_DIN),
    .buttons(buttons),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .status(status), .status_updated(status_updated),
    .ps2_key(ps2_key)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status_updated) upd_cnt++;
    if (IO_WAIT) wait_hi++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] w);
    int lat, wid;
    @(negedge clk);
    IO_DOUT = w;
    IO_STROBE = 1'b1;
    lat = 0;
    wid = 0;
    while (!IO_WAIT && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    while (IO_WAIT && wid < 40) begin
      @(negedge clk);
      wid++;
    end
    IO_STROBE = 1'b0;
    chk("wait_lat", lat, 2);
    chk("wait_len", wid, WC);
  endtask

  task automatic poke(input logic [15:0] w);
    @(negedge clk);
    IO_DOUT = w;
    IO_STROBE = 1'b1;
    cyc(2);
    IO_STROBE = 1'b0;
    cyc(4);
  endtask

  task automatic open_uio();
    @(negedge clk);
    IO_UIO = 1'b1;
    cyc(2);
  endtask

  task automatic close_uio();
    @(negedge clk);
    IO_UIO = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset_n = 1'b0;
    IO_UIO = 1'b0;
    IO_FPGA = 1'b0;
    IO_STROBE = 1'b0;
    IO_DOUT = '0;
    cyc(3);
    chk("rst_btn", buttons, 0);
    chk("rst_j0", joystick_0, 0);
    chk("rst_j1", joystick_1, 0);
    chk("rst_st", status, 0);
    chk("rst_upd", status_updated, 0);
    chk("rst_ps2", ps2_key, 0);
    chk("rst_wait", IO_WAIT, 0);
    chk("rst_din", IO_DIN, 0);
    reset_n = 1'b1;
    cyc(2);

    open_uio();
    strobe(16'h0002);
    strobe(16'h1234);
    chk("j0_lo", joystick_0, 32'h0000_1234);
    strobe(16'hABCD);
    close_uio();
    chk("j0", joystick_0, 32'hABCD_1234);
    chk("j0_j1", joystick_1, 0);
    chk("j0_btn", buttons, 0);
    chk("j0_st", status, 0);
    chk("j0_din", IO_DIN, 0);

    open_uio();
    strobe(16'h001E);
    strobe(16'h5678);
    chk("st_stage", status, 0);
    strobe(16'h9ABC);
    close_uio();
    chk("st", status, 32'h9ABC_5678);
    chk("st_upd", upd_cnt, 1);

    open_uio();
    strobe(16'h001E);
    strobe(16'h1111);
    close_uio();
    chk("st_part", status, 32'h9ABC_5678);
    chk("st_part_upd", upd_cnt, 1);

    open_uio();
    strobe(16'h0029);
    chk("rd_lo", IO_DIN, 16'h5678);
    strobe(16'h0000);
    chk("rd_hi", IO_DIN, 16'h9ABC);
    strobe(16'h0000);
    chk("rd_end", IO_DIN, 0);
    close_uio();
    open_uio();
    strobe(16'h0029);
    chk("rd_lo2", IO_DIN, 16'h5678);
    close_uio();
    chk("rd_idle", IO_DIN, 0);

    open_uio();
    strobe(16'h0001);
    strobe(16'hBEEF);
    strobe(16'h1111);
    close_uio();
    chk("btn", buttons, 16'hBEEF);

    open_uio();
    strobe(16'h0003);
    strobe(16'h5555);
    strobe(16'hAAAA);
    close_uio();
    chk("j1", joystick_1, 32'hAAAA_5555);

    open_uio();
    strobe(16'h0005);
    strobe(16'h00E0);
    strobe(16'h00F0);
    strobe(16'h0075);
`ifdef HPS_UIO_PS2_EN
    chk("ps2_a", ps2_key, 11'h575);
`else
    chk("ps2_a", ps2_key, 0);
`endif
    strobe(16'h001C);
    close_uio();
`ifdef HPS_UIO_PS2_EN
    chk("ps2_b", ps2_key, 11'h21C);
`else
    chk("ps2_b", ps2_key, 0);
`endif

    w0 = wait_hi;
    open_uio();
    IO_FPGA = 1'b1;
    poke(16'h0001);
    poke(16'h0000);
    IO_FPGA = 1'b0;
    close_uio();
    chk("fpga_btn", buttons, 16'hBEEF);
    chk("fpga_wait", wait_hi - w0, 0);

    w0 = wait_hi;
    poke(16'h0001);
    poke(16'h0000);
    chk("nouio_btn", buttons, 16'hBEEF);
    chk("nouio_wait", wait_hi - w0, 0);

    open_uio();
    strobe(16'h0001);
    w0 = wait_hi;
    @(negedge clk);
    IO_DOUT = 16'h0000;
    IO_STROBE = 1'b1;
    IO_UIO = 1'b0;
    cyc(3);
    IO_STROBE = 1'b0;
    cyc(3);
    chk("fall_btn", buttons, 16'hBEEF);
    chk("fall_wait", wait_hi - w0, 0);

    open_uio();
    strobe(16'h0002);
    w0 = wait_hi;
    @(negedge clk);
    IO_DOUT = 16'h4321;
    IO_STROBE = 1'b1;
    cyc(10);
    IO_STROBE = 1'b0;
    cyc(4);
    chk("hold_wait", wait_hi - w0, WC);
    close_uio();
    chk("hold_j0", joystick_0, 32'hABCD_4321);

    open_uio();
    strobe(16'h001E);
    strobe(16'h2222);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_st", status, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(3);
    close_uio();
    chk("rr_btn", buttons, 0);
    chk("rr_j0", joystick_0, 0);
    chk("rr_j1", joystick_1, 0);
    chk("rr_st", status, 0);
    chk("rr_din", IO_DIN, 0);
    chk("rr_wait", IO_WAIT, 0);
    chk("rr_upd", upd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
